// File: rtl/logic_not_gate.sv
// logic_not_gate: bitwise inverter with registered copy, valid flag, saturating activity counter; optional chk_err via LOGIC_NOT_CHECK_EN (ports clk rst A en -> Y Y_q valid_q act_cnt [chk_err])
module logic_not_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] act_cnt
`ifdef LOGIC_NOT_CHECK_EN
  ,
  output logic             chk_err
`else
`endif
);
  logic [WIDTH-1:0] a_prev;
  assign Y = ~A;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Y_q     <= {WIDTH{1'b1}};
      valid_q <= 1'b0;
      a_prev  <= '0;
      act_cnt <= '0;
    end else if (en) begin
      Y_q     <= ~A;
      valid_q <= 1'b1;
      a_prev  <= A;
      act_cnt <= (A != a_prev && act_cnt != {CNT_W{1'b1}}) ? act_cnt + CNT_W'(1) : act_cnt;
    end
`ifdef LOGIC_NOT_CHECK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) chk_err <= 1'b0;
    else if (valid_q && |(Y_q ^ ~a_prev)) chk_err <= 1'b1;
`else
`endif
endmodule

// File: tb/tb_logic_not_gate.sv
// tb_logic_not_gate: randomized check of logic_not_gate against a behavioural model
module tb_logic_not_gate;
  logic clk = 0, rst = 0, en = 0;
  logic [7:0] A8 = 0, Y8, Yq8;
  logic [3:0] cnt8;
  logic v8;
  logic A1 = 0, Y1, Yq1, v1;
  logic [1:0] cnt1;
  int checks = 0, failures = 0;
  logic [7:0] m_yq8, m_prev8;
  int m_cnt8, m_cnt1;
  logic m_v8, m_yq1, m_prev1, m_v1;
`ifdef LOGIC_NOT_CHECK_EN
  logic ce8, ce1;
  logic m_ce8 = 0;
`endif
  always #5 clk = ~clk;
  logic_not_gate #(.WIDTH(8), .CNT_W(4)) u8 (.clk(clk), .rst(rst), .A(A8), .en(en), .Y(Y8), .Y_q(Yq8),
    .valid_q(v8), .act_cnt(cnt8)
`ifdef LOGIC_NOT_CHECK_EN
    , .chk_err(ce8)
`endif
  );
  logic_not_gate #(.WIDTH(1), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .A(A1), .en(en), .Y(Y1), .Y_q(Yq1),
    .valid_q(v1), .act_cnt(cnt1)
`ifdef LOGIC_NOT_CHECK_EN
    , .chk_err(ce1)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_yq8 = 8'hFF; m_v8 = 0; m_prev8 = 0; m_cnt8 = 0;
    m_yq1 = 1; m_v1 = 0; m_prev1 = 0; m_cnt1 = 0;
`ifdef LOGIC_NOT_CHECK_EN
    m_ce8 = 0;
`endif
  endtask
  task automatic model_capture(input logic [7:0] a8, input logic a1);
    if (a8 != m_prev8) m_cnt8 = (m_cnt8 + 1 > 15) ? 15 : m_cnt8 + 1;
    if (a1 != m_prev1) m_cnt1 = (m_cnt1 + 1 > 3) ? 3 : m_cnt1 + 1;
    m_yq8 = ~a8; m_v8 = 1; m_prev8 = a8;
    m_yq1 = ~a1; m_v1 = 1; m_prev1 = a1;
  endtask
  task automatic check_regs();
    check("yq8", {24'b0, Yq8}, {24'b0, m_yq8});
    check("valid8", {31'b0, v8}, {31'b0, m_v8});
    check("cnt8", {28'b0, cnt8}, m_cnt8);
    check("yq1", {31'b0, Yq1}, {31'b0, m_yq1});
    check("valid1", {31'b0, v1}, {31'b0, m_v1});
    check("cnt1", {30'b0, cnt1}, m_cnt1);
`ifdef LOGIC_NOT_CHECK_EN
    check("chk8", {31'b0, ce8}, {31'b0, m_ce8});
    check("chk1", {31'b0, ce1}, 0);
`endif
  endtask
  task automatic check_comb(input logic [7:0] a8, input logic a1);
    logic [7:0] e8;
    logic e1;
    e8 = ~a8;
    e1 = ~a1;
    check("y8", {24'b0, Y8}, {24'b0, e8});
    check("y1", {31'b0, Y1}, {31'b0, e1});
  endtask
  task automatic step(input logic e, input logic [7:0] a8, input logic a1, input logic r);
    @(negedge clk);
    rst = 0; en = e; A8 = a8; A1 = a1;
    #1 check_comb(a8, a1);
    if (r) begin
      rst = 1;
      #1 model_reset();
      check_regs();
    end
    @(posedge clk);
    if (!r && e) model_capture(a8, a1);
    #1 check_regs();
  endtask
  initial begin
    logic [7:0] a;
    logic [7:0] tmp;
    #1 A1 = 0;
    #1 check_comb(8'h00, 1'b0);
    A1 = 1; A8 = 8'h3C;
    #1 check_comb(8'h3C, 1'b1);
    rst = 1;
    #1 model_reset();
    check_regs();
    step(1, 8'hA5, 1'b1, 0);
    check("yq8_a5", {24'b0, Yq8}, 32'h5A);
    step(0, 8'h00, 1'b0, 0);
    step(0, 8'h55, 1'b1, 0);
    step(0, 8'hFF, 1'b0, 0);
    step(1, 8'h00, 1'b0, 1);
    for (int i = 0; i < 6; i++) step(1, 8'(i), 1'(i + 1), 0);
    check("cnt1_sat", {30'b0, cnt1}, 3);
    step(1, 8'hFF, 1'b1, 1);
    step(1, 8'h00, 1'b0, 0);
    check("cnt8_after_rst", {28'b0, cnt8}, 0);
    a = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) a = 8'($urandom);
      step($urandom_range(0, 3) != 0, a, 1'($urandom), $urandom_range(0, 40) == 0);
    end
`ifdef LOGIC_NOT_CHECK_EN
    step(1, 8'h12, 1'b0, 0);
    @(negedge clk);
    en = 0;
    tmp = Yq8 ^ 8'h01;
    force u8.Y_q = tmp;
    @(posedge clk);
    #1 release u8.Y_q;
    m_ce8 = 1;
    m_yq8 = tmp;
    check_regs();
    step(1, 8'h34, 1'b1, 0);
    step(0, 8'h56, 1'b0, 0);
    check("chk8_sticky", {31'b0, ce8}, 1);
    step(0, 8'h00, 1'b0, 1);
    step(1, 8'h77, 1'b1, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
